// File: rtl/pc_ctrl.sv
// Program-counter control: run FSM, writable jump-target LUT and return stack.
// Branch and target are driven combinationally so the PC can sample them on the same edge.
module pc_ctrl #(
  parameter int D     = 8,
  parameter int L     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_req,
  input  logic [D-1:0] prog_ctr,
  input  logic [2:0]   br_op,
  input  logic [L-1:0] lut_idx,
  input  logic         zero_flag,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic         start,
  output logic         branch,
  output logic [D-1:0] target,
  output logic         running,
  output logic         done,
  output logic         stack_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BZ   = 3'd2;
  localparam logic [2:0] OP_BNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  localparam logic [AW:0]  SP_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]  SP_FULL = (AW + 1)'(DEPTH);
  localparam logic [D-1:0] PC_ONE  = {{(D-1){1'b0}}, 1'b1};

  logic [1:0]    state, state_nxt;
  logic [AW:0]   sp;
  logic [AW:0]   sp_dec;
  logic [D-1:0]  lut [2**L];
  logic [D-1:0]  stk [DEPTH];
  logic          br_raw;
  logic [D-1:0]  tgt_raw;
  logic          push, pop, err_set;
  logic          full, empty;

  assign full   = (sp == SP_FULL);
  assign empty  = (sp == '0);
  assign sp_dec = sp - SP_ONE;

  always_comb begin
    state_nxt = state;
    br_raw    = 1'b0;
    tgt_raw   = '0;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_nxt = S_ARM;
      S_ARM:  if (!start_req) state_nxt = S_RUN;
      S_RUN: begin
        case (br_op)
          OP_JMP: begin
            br_raw  = 1'b1;
            tgt_raw = lut[lut_idx];
          end
          OP_BZ: begin
            br_raw  = zero_flag;
            tgt_raw = lut[lut_idx];
          end
          OP_BNZ: begin
            br_raw  = !zero_flag;
            tgt_raw = lut[lut_idx];
          end
          OP_CALL: begin
            if (full) err_set = 1'b1;
            else begin
              br_raw  = 1'b1;
              tgt_raw = lut[lut_idx];
              push    = 1'b1;
            end
          end
          OP_RET: begin
            if (empty) err_set = 1'b1;
            else begin
              br_raw  = 1'b1;
              tgt_raw = stk[sp_dec[AW-1:0]];
              pop     = 1'b1;
            end
          end
          OP_HALT: begin
            br_raw    = 1'b1;
            tgt_raw   = prog_ctr;
            state_nxt = S_HALT;
          end
          default: br_raw = 1'b0;
        endcase
      end
      S_HALT: begin
        br_raw  = 1'b1;
        tgt_raw = prog_ctr;
        if (start_req) state_nxt = S_ARM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start   = (state == S_IDLE) || (state == S_ARM);
  assign running = (state == S_RUN);
  assign done    = (state == S_HALT);
  assign branch  = br_raw;
  // Target is forced to zero whenever no branch is requested.
  assign target  = br_raw ? tgt_raw : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      for (int i = 0; i < 2**L; i++) lut[i] <= '0;
    end else begin
      state <= state_nxt;
      // Entering ARM starts a fresh program: empty stack, error cleared.
      if (state != S_ARM && state_nxt == S_ARM) begin
        sp        <= '0;
        stack_err <= 1'b0;
      end else begin
        if (push) begin
          stk[sp[AW-1:0]] <= prog_ctr + PC_ONE;
          sp              <= sp + SP_ONE;
        end
        if (pop) sp <= sp_dec;
        if (err_set) stack_err <= 1'b1;
      end
      if (lut_we) lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios then randomized traffic, compared each cycle
// against a mode/queue/array reference model.
module tb_pc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_req;
  logic [7:0] prog_ctr;
  logic [2:0] br_op;
  logic [3:0] lut_idx;
  logic       zero_flag;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [7:0] lut_wdata;
  logic       start, branch, running, done, stack_err;
  logic [7:0] target;

  pc_ctrl #(.D(8), .L(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .prog_ctr(prog_ctr),
    .br_op(br_op), .lut_idx(lut_idx), .zero_flag(zero_flag), .lut_we(lut_we),
    .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .start(start), .branch(branch),
    .target(target), .running(running), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_ARM, M_RUN, M_HALT} mode_t;
  mode_t      mode;
  logic [7:0] mlut [16];
  logic [7:0] rq [$];
  logic       merr;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    rq.delete();
    merr = 1'b0;
    for (int i = 0; i < 16; i++) mlut[i] = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    logic       e_br;
    logic [7:0] e_tg;
    e_br = 1'b0;
    e_tg = 8'h00;
    if (mode == M_RUN) begin
      case (br_op)
        3'd1: begin e_br = 1'b1; e_tg = mlut[lut_idx]; end
        3'd2: begin e_br = zero_flag; e_tg = zero_flag ? mlut[lut_idx] : 8'h00; end
        3'd3: begin e_br = !zero_flag; e_tg = !zero_flag ? mlut[lut_idx] : 8'h00; end
        3'd4: if (rq.size() < 4) begin e_br = 1'b1; e_tg = mlut[lut_idx]; end
        3'd5: if (rq.size() > 0) begin e_br = 1'b1; e_tg = rq[rq.size()-1]; end
        3'd6: begin e_br = 1'b1; e_tg = prog_ctr; end
        default: e_br = 1'b0;
      endcase
    end else if (mode == M_HALT) begin
      e_br = 1'b1;
      e_tg = prog_ctr;
    end
    chk_val({tag, ".start"},   32'(start),     32'(mode == M_IDLE || mode == M_ARM));
    chk_val({tag, ".running"}, 32'(running),   32'(mode == M_RUN));
    chk_val({tag, ".done"},    32'(done),      32'(mode == M_HALT));
    chk_val({tag, ".branch"},  32'(branch),    32'(e_br));
    chk_val({tag, ".target"},  32'(target),    32'(e_tg));
    chk_val({tag, ".err"},     32'(stack_err), 32'(merr));
  endtask

  task automatic model_step();
    logic [7:0] ra;
    case (mode)
      M_IDLE: if (start_req) begin mode = M_ARM; rq.delete(); merr = 1'b0; end
      M_ARM:  if (!start_req) mode = M_RUN;
      M_HALT: if (start_req) begin mode = M_ARM; rq.delete(); merr = 1'b0; end
      default: begin
        if (br_op == 3'd4) begin
          if (rq.size() < 4) begin ra = prog_ctr + 8'd1; rq.push_back(ra); end
          else merr = 1'b1;
        end else if (br_op == 3'd5) begin
          if (rq.size() > 0) void'(rq.pop_back());
          else merr = 1'b1;
        end else if (br_op == 3'd6) mode = M_HALT;
      end
    endcase
    if (lut_we) mlut[lut_waddr] = lut_wdata;
  endtask

  // Inputs are set just after a falling edge; outputs are checked 2 time units later.
  task automatic cycle(input string tag);
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  task automatic drive(input logic sr, input logic [2:0] op, input logic [3:0] idx,
                       input logic zf, input logic [7:0] pc);
    start_req = sr; br_op = op; lut_idx = idx; zero_flag = zf; prog_ctr = pc;
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk_val({tag, ".start"},   32'(start),     32'd1);
    chk_val({tag, ".branch"},  32'(branch),    32'd0);
    chk_val({tag, ".target"},  32'(target),    32'd0);
    chk_val({tag, ".running"}, 32'(running),   32'd0);
    chk_val({tag, ".done"},    32'(done),      32'd0);
    chk_val({tag, ".err"},     32'(stack_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic launch();
    drive(1'b1, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle("launch_arm");
    drive(1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle("launch_run");
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 8'h00;
    model_reset();
    #3;
    chk_val("reset.start",  32'(start),  32'd1);
    chk_val("reset.branch", 32'(branch), 32'd0);
    chk_val("reset.target", 32'(target), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: start_req high three cycles, low, then RUN; LUT[3]=0x40 written meanwhile
    drive(1'b1, 3'd1, 4'd3, 1'b0, 8'h00);
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 8'h40;
    cycle("t1_idle");
    cycle("t1_arm0");
    cycle("t1_arm1");
    drive(1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle("t1_fall");
    chk_val("t1.running_now", 32'(running), 32'd1);
    cycle("t1_run");

    // 2: jmp / bz not taken
    drive(1'b0, 3'd1, 4'd3, 1'b0, 8'h05);
    cycle("t2_jmp");
    drive(1'b0, 3'd2, 4'd3, 1'b0, 8'h06);
    cycle("t2_bz_nt");
    drive(1'b0, 3'd2, 4'd3, 1'b1, 8'h06);
    cycle("t2_bz_t");
    drive(1'b0, 3'd3, 4'd3, 1'b0, 8'h06);
    cycle("t2_bnz_t");

    // 3: call / ret including wrap of return address
    drive(1'b0, 3'd4, 4'd3, 1'b0, 8'h10);
    cycle("t3_call");
    drive(1'b0, 3'd0, 4'd0, 1'b0, 8'h40);
    cycle("t3_none");
    drive(1'b0, 3'd5, 4'd0, 1'b0, 8'h41);
    cycle("t3_ret");
    drive(1'b0, 3'd4, 4'd3, 1'b0, 8'hFF);
    cycle("t3_call_wrap");
    drive(1'b0, 3'd5, 4'd0, 1'b0, 8'h40);
    cycle("t3_ret_wrap");

    // 4: overflow and underflow
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd4, 4'd3, 1'b0, 8'(8'h30 + i));
      cycle("t4_call");
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd5, 4'd0, 1'b0, 8'h40);
      cycle("t4_ret");
    end
    drive(1'b1, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle("t4_sr_ignored");

    // 5: halt, held target, restart clears error
    drive(1'b0, 3'd6, 4'd0, 1'b0, 8'h22);
    cycle("t5_halt");
    drive(1'b0, 3'd1, 4'd3, 1'b0, 8'h22);
    cycle("t5_held0");
    cycle("t5_held1");
    drive(1'b1, 3'd0, 4'd0, 1'b0, 8'h22);
    cycle("t5_restart");
    cycle("t5_arm");
    drive(1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle("t5_fall");

    // 6: async reset mid-call, then LUT and stack must be cleared
    drive(1'b0, 3'd4, 4'd3, 1'b0, 8'h50);
    cycle("t6_call");
    drive(1'b0, 3'd4, 4'd3, 1'b0, 8'h51);
    async_reset("t6_reset");
    launch();
    drive(1'b0, 3'd1, 4'd3, 1'b0, 8'h00);
    cycle("t6_jmp_zero");
    drive(1'b0, 3'd5, 4'd0, 1'b0, 8'h00);
    cycle("t6_ret_empty");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6 && $urandom_range(0, 2) != 0) op = 3'd4;
      drive(($urandom_range(0, 9) == 0), op, 4'($urandom), 1'($urandom), 8'($urandom));
      if (mode == M_HALT && $urandom_range(0, 3) == 0) start_req = 1'b1;
      if (mode == M_ARM && $urandom_range(0, 1) == 0) start_req = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        lut_we = 1'b1; lut_waddr = 4'($urandom); lut_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 149) == 0) async_reset("rnd_reset");
      else cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
